// File: rtl/cardinal_regfile_sb_pkg.sv
// rtl/cardinal_regfile_sb_pkg.sv - shared lane-mask helpers and default geometry for the register file
package cardinal_regfile_sb_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_LANE_W = 8;
    localparam int DEF_NREG   = 32;
    localparam int DEF_NL     = DEF_DATA_W / DEF_LANE_W;
    localparam int DEF_AW     = $clog2(DEF_NREG);

    // Legacy PPP write-select encodings mapped onto an 8-lane mask, lane 0 in bit 0 (MSB).
    function automatic logic [0:7] ppp_to_mask(input logic [2:0] ppp);
        logic [0:7] m;
        case (ppp)
            3'b000:  m = 8'hFF;
            3'b001:  m = 8'hF0;
            3'b010:  m = 8'h0F;
            3'b011:  m = 8'hAA;
            3'b100:  m = 8'h55;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    function automatic int lane_lsb(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/cardinal_sb_counter.sv
// rtl/cardinal_sb_counter.sv - saturating pending-write counter with clear for one register
module cardinal_sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             full_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             inc_ok;
    logic             dec_ok;

    assign full_o      = (cnt_q == {CNT_W{1'b1}});
    assign inc_ok      = inc_i && !full_o;
    assign dec_ok      = dec_i && (cnt_q != '0);
    assign underflow_o = dec_i && (cnt_q == '0);
    assign cnt_o       = cnt_q;

    // Simultaneous issue and retire cancel; clear beats both.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cardinal_regfile_sb.sv
// rtl/cardinal_regfile_sb.sv - lane-masked register file with per-lane bypass and pending-write scoreboard
module cardinal_regfile_sb
    import cardinal_regfile_sb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LANE_W  = DEF_LANE_W,
    parameter int NREG    = DEF_NREG,
    parameter int NRD     = 2,
    parameter int CNT_W   = 2,
    parameter int R0_ZERO = 1,
    localparam int NL     = DATA_W / LANE_W,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [0:NRD*AW-1]      rd_addr,
    output logic [0:NRD*DATA_W-1]  rd_data,
    output logic [0:NRD-1]         rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [0:NL-1]          wr_mask,
    input  logic [0:DATA_W-1]      wr_data,
    input  logic                   wr_retire,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_rd,
    output logic                   iss_ready,
    input  logic                   sb_clear,
    output logic                   sb_err
);

    logic [0:DATA_W-1] regs_q [NREG];
    logic [CNT_W-1:0]  cnt    [NREG];
    logic [NREG-1:0]   full;
    logic [NREG-1:0]   uflow;
    logic              sb_err_q;
    logic              wr_live;
    logic              retire;
    logic [AW-1:0]     ra;

    function automatic logic is_r0(input logic [AW-1:0] a);
        return (R0_ZERO != 0) && (a == '0);
    endfunction

    assign wr_live   = wr_en && !is_r0(wr_addr);
    assign retire    = wr_en && wr_retire && !is_r0(wr_addr);
    assign iss_ready = is_r0(iss_rd) || !full[iss_rd];
    assign sb_err    = sb_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_live) begin
            for (int k = 0; k < NL; k++) begin
                if (wr_mask[k]) begin
                    regs_q[wr_addr][lane_lsb(k, LANE_W) +: LANE_W] <= wr_data[lane_lsb(k, LANE_W) +: LANE_W];
                end
            end
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_sb
        localparam logic [AW-1:0] RA = AW'(r);
        logic trk;
        assign trk = !is_r0(RA);

        cardinal_sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i       (clk),
            .rst_n_i     (reset),
            .clear_i     (sb_clear),
            .inc_i       (trk && iss_valid && (iss_rd == RA)),
            .dec_i       (trk && retire && (wr_addr == RA)),
            .cnt_o       (cnt[r]),
            .full_o      (full[r]),
            .underflow_o (uflow[r])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_err_q <= 1'b0;
        end else if (|uflow) begin
            sb_err_q <= 1'b1;
        end
    end

    // A last outstanding write retiring this cycle is forwarded, so it no longer stalls.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (!is_r0(ra)) begin
                for (int k = 0; k < NL; k++) begin
                    rd_data[i*DATA_W + lane_lsb(k, LANE_W) +: LANE_W] =
                        (wr_en && wr_mask[k] && (wr_addr == ra)) ?
                        wr_data[lane_lsb(k, LANE_W) +: LANE_W] :
                        regs_q[ra][lane_lsb(k, LANE_W) +: LANE_W];
                end
                rd_busy[i] = (cnt[ra] != '0) &&
                             !((cnt[ra] == CNT_W'(1)) && retire && (wr_addr == ra));
            end
        end
    end

endmodule

// File: doc/cardinal_regfile_sb.md
Name: cardinal_regfile_sb

Overview:
Parametrised successor to the processor's register file. It generalises the fixed 64-bit, 8-lane PPP write select to a configurable DATA_W/LANE_W lane mask, and the two fixed read ports to NRD ports. It adds per-lane write-back bypass and a per-register pending-write scoreboard. The scoreboard lets a deeper pipeline generate RAW stalls from the register file instead of comparing rD fields in EX. It sits in ID; issue comes from ID, write/retire comes from WB.

Parameters:
DATA_W, 64, register width in bits; bit 0 is the MSB.
LANE_W, 8, lane width; DATA_W % LANE_W == 0; NL = DATA_W/LANE_W lanes; lane 0 = bits [0:LANE_W-1].
NREG, 32, number of registers; AW = $clog2(NREG).
NRD, 2, number of read ports.
CNT_W, 2, scoreboard counter width; up to 2^CNT_W-1 writes in flight per register.
R0_ZERO, 1, 1 = register 0 reads zero, ignores writes and is never tracked.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
rd_addr  in  NRD*AW  read addresses; port i at [i*AW:(i+1)*AW-1].
rd_data  out  NRD*DATA_W  read data with bypass applied; port i at [i*DATA_W:(i+1)*DATA_W-1].
rd_busy  out  NRD  port i's register has an outstanding write (RAW hazard).
wr_en  in  1  write strobe from WB.
wr_addr  in  AW  write address.
wr_mask  in  NL  lane write enables (generalised PPP); bit 0 = lane 0.
wr_data  in  DATA_W  write data.
wr_retire  in  1  this write completes one issued instruction; decrements the count.
iss_valid  in  1  ID issues an instruction that will write iss_rd.
iss_rd  in  AW  destination of the issued instruction.
iss_ready  out  1  iss_rd counter not saturated.
sb_clear  in  1  pipeline flush: zero all counters.
sb_err  out  1  sticky: a retire arrived with count 0.

Behaviour:
- Reset (reset=0, async): all registers 0, all counters 0, sb_err=0. After reset, rd_data=0 and rd_busy=0. iss_ready=1.
- Write: on a rising edge with wr_en=1, each lane k with wr_mask[k]=1 takes wr_data lane k. Other lanes hold. wr_mask=0 writes nothing but still retires if wr_retire=1.
- Read: combinational, zero latency. rd_data lane k = wr_data lane k if wr_en && wr_mask[k] && wr_addr==rd_addr, else the array value. Bypass is per lane, never whole-word.
- R0_ZERO=1 and address 0:
  - reads return 0, with no bypass;
  - writes are dropped;
  - issue and retire are ignored;
  - rd_busy=0 and iss_ready=1 for address 0.
- Counter update per register r, on a rising edge:
  - inc = iss_valid && iss_ready && iss_rd==r;
  - dec = wr_en && wr_retire && wr_addr==r && cnt[r]!=0;
  - inc && dec leaves the count unchanged; inc alone adds 1; dec alone subtracts 1.
- iss_ready = cnt[iss_rd] != 2^CNT_W-1. An issue with iss_ready=0 is ignored and the count holds.
- rd_busy[i] = cnt[a]!=0, except it is 0 when cnt[a]==1 and a retire to a is present this cycle (the retiring data is bypassed).
- A partial-lane write is only hazard-free if the consumer needs just the written lanes. ID stalls on rd_busy regardless of mask.
- Retire with cnt==0: the count stays 0 and sb_err is set. sb_err clears only on reset.
- sb_clear=1: all counters become 0 on the next edge. An issue in the same cycle is dropped (clear wins). A register write in the same cycle still updates the array.
- Reset asserted mid-operation: array and counters clear immediately; no pending state survives.
- Counters never wrap in either direction.

Decomposition:
- Shared package: lane-mask helpers, including a PPP-to-mask function that maps 000/001/010/011/100 to 8'hFF/F0/0F/AA/55 for NL=8. Also the $clog2-derived AW and NL localparams.
- One natural sub-module: cardinal_sb_counter. It is a saturating up/down counter with clear, instantiated per register through a generate loop.
- The array and bypass stay in the top module.

Test Plan:
1. Reset low mid-stream, with r5=64'h1122334455667788 previously written → rd_data for r5 reads 0 immediately; rd_busy=0; sb_err=0.
2. Write r3 with all lanes = 64'hFFFF..., then write r3 with wr_mask=8'hF0 and data 0 while reading r3 in the same cycle → rd_data=64'h00000000FFFFFFFF in that cycle and after the edge.
3. Issue r7 three times (CNT_W=2) → iss_ready=0; a 4th issue is ignored. Three retires → count returns to 0. rd_busy is 0 during the third retire cycle.
4. Issue and retire r9 on the same edge with cnt=1 → cnt stays 1 and rd_busy=1.
5. sb_clear together with iss_valid to r4 while r4, r6 are pending → all counters 0 and r4 not busy. A later retire to r4 sets sb_err=1.
6. R0_ZERO=1: write 64'hDEAD to r0 and issue r0 → reads 0, rd_busy=0, no sb_err on retire.
